// File: rtl/fifo_decim_reader.sv
// fifo_decim_reader: consumer end of a FIFO read port (1-cycle read latency).
// Pops samples, keeps 1 of every DECIMATION, and presents kept samples on a
// valid/ready stream through a 2-entry skid buffer.
// Optional feature macro: FIFO_RD_STATS_EN adds a 32-bit handshake counter
// port (sample_count).
module fifo_decim_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int DECIMATION = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]           sample_count
`endif
);

  localparam int PW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIMATION - 1);

  logic [1:0]            count_reg, count_next;
  logic                  inflight_reg;
  logic [PW-1:0]         phase_reg, phase_next;
  logic [DATA_WIDTH-1:0] head_reg;
  logic [DATA_WIDTH-1:0] tail_reg;
  logic                  pop;
  logic                  capture;
  logic                  wr_tail;
  logic [2:0]            credit;

  // Handshake, pop credit and buffer bookkeeping.
  always_comb begin
    out_valid = (count_reg != 2'd0);
    out_data  = head_reg;
    pop       = out_valid && out_ready;
    // Entries held plus the word in flight, minus the one leaving this cycle.
    credit     = {1'b0, count_reg} + {2'b0, inflight_reg} - {2'b0, pop};
    // rst gating keeps the pop request low for the whole reset interval.
    fifo_rd_en = rst && !fifo_empty && (credit < 3'd2);
    capture    = inflight_reg && (phase_reg == '0);
    // Slot the captured word lands in after any simultaneous head advance.
    wr_tail    = count_reg[1] || (count_reg[0] && !pop);
    count_next = count_reg + {1'b0, capture} - {1'b0, pop};
    phase_next = phase_reg;
    if (inflight_reg) begin
      phase_next = (phase_reg == PHASE_LAST) ? '0 : phase_reg + PW'(1);
    end
  end

  // Occupancy, in-flight flag and decimation phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg    <= 2'd0;
      inflight_reg <= 1'b0;
      phase_reg    <= '0;
    end else begin
      count_reg    <= count_next;
      inflight_reg <= fifo_rd_en;
      phase_reg    <= phase_next;
    end
  end

  // Skid buffer: head shifts forward on pop, captured word fills first free slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      if (capture && !wr_tail) begin
        head_reg <= fifo_dout;
      end else if (pop) begin
        head_reg <= tail_reg;
      end
      if (capture && wr_tail) begin
        tail_reg <= fifo_dout;
      end
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [31:0] sample_count_reg;

  // Counts output handshakes since reset; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_count_reg <= 32'd0;
    end else if (pop) begin
      sample_count_reg <= sample_count_reg + 32'd1;
    end
  end

  assign sample_count = sample_count_reg;
`endif

endmodule

// File: tb/tb_fifo_decim_reader.sv
// Bench for fifo_decim_reader: two instances (DECIMATION 1 and 4) fed by FIFO
// models; a per-instance scoreboard derives the expected stream from the
// popped-word index (keep index % DECIMATION == 0, cleared on reset).
module tb_fifo_decim_reader;
  localparam int DW    = 16;
  localparam int MEMSZ = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] fifo_dout [2];
  logic [DW-1:0] out_data  [2];
  logic [1:0]    fifo_empty, fifo_rd_en, out_valid, out_ready, hold_empty;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]   sample_count [2];
`endif

  logic [DW-1:0] mem [2][MEMSZ];
  int wr_ptr [2] = '{0, 0};
  int rd_ptr [2] = '{0, 0};
  int acc_cnt [2] = '{0, 0};
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int D = (gi == 0) ? 1 : 4;

    fifo_decim_reader #(.DATA_WIDTH(DW), .DECIMATION(D)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_dout  (fifo_dout[gi]),
      .fifo_empty (fifo_empty[gi]),
      .fifo_rd_en (fifo_rd_en[gi]),
      .out_data   (out_data[gi]),
      .out_valid  (out_valid[gi]),
      .out_ready  (out_ready[gi])
`ifdef FIFO_RD_STATS_EN
      ,
      .sample_count (sample_count[gi])
`endif
    );

    // FIFO model: 1-cycle read latency, independent of the reader's reset.
    assign fifo_empty[gi] = hold_empty[gi] || (rd_ptr[gi] == wr_ptr[gi]);
    always @(posedge clk) begin
      if (fifo_rd_en[gi]) begin
        fifo_dout[gi] <= mem[gi][rd_ptr[gi]];
        rd_ptr[gi]    <= rd_ptr[gi] + 1;
      end
    end

    // Scoreboard: inputs are stable at the falling edge for the next rising edge.
    logic [DW-1:0] exp_q [$];
    int            pop_idx = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    always @(negedge clk) begin
      if (!rst) begin
        exp_q.delete();
        pop_idx    <= 0;
        stall_prev <= 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", out_valid[gi], 1'b1);
          check("stall_data", out_data[gi], stall_data);
        end
        check("rd_en_while_empty", fifo_rd_en[gi] && fifo_empty[gi], 1'b0);
        if (out_valid[gi] && out_ready[gi]) begin
          check("out_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            check("out_data", out_data[gi], exp_q.pop_front());
          end
          acc_cnt[gi] <= acc_cnt[gi] + 1;
        end
        if (fifo_rd_en[gi]) begin
          if (pop_idx % D == 0) exp_q.push_back(mem[gi][rd_ptr[gi]]);
          pop_idx <= pop_idx + 1;
        end
        check("outstanding_le_2", exp_q.size() <= 2, 1'b1);
        stall_prev <= out_valid[gi] && !out_ready[gi];
        stall_data <= out_data[gi];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int f, input logic [DW-1:0] w);
    mem[f][wr_ptr[f]] = w;
    wr_ptr[f]++;
  endtask

  initial begin
    logic          found;
    logic [DW-1:0] nxt0, nxt1;
    int            acc_rel;
    out_ready  = 2'b00;
    hold_empty = 2'b00;
    // Preload while in reset so the pop-request gating is exercised.
    for (int i = 0; i < 128; i++) push(0, DW'(i));
    for (int i = 0; i < 32; i++)  push(1, DW'(i));
    tick(3);
    for (int i = 0; i < 2; i++) begin
      check("reset_valid", out_valid[i], 1'b0);
      check("reset_rd_en", fifo_rd_en[i], 1'b0);
      check("reset_data", out_data[i], '0);
    end

    // Test 1 and 2: full-rate pass-through and 1-of-4 decimation.
    out_ready = 2'b11;
    rst = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (fifo_rd_en[0]) begin
        found = 1'b1;
        break;
      end
    end
    check("first_rd_en_seen", found, 1'b1);
    @(negedge clk);
    check("latency_t1_valid", out_valid[0], 1'b0);
    @(negedge clk);
    check("latency_t2_valid", out_valid[0], 1'b1);
    check("first_data", out_data[0], 16'd0);
    for (int k = 1; k < 128; k++) begin
      @(negedge clk);
      check("no_gap_valid", out_valid[0], 1'b1);
    end
    tick(6);
    check("t1_count", acc_cnt[0], 32'd128);
    check("t2_count", acc_cnt[1], 32'd8);

    // Test 3: random backpressure.
    for (int i = 0; i < 64; i++) push(0, DW'($urandom));
    for (int i = 0; i < 20; i++) push(1, DW'($urandom));
    for (int k = 0; k < 3000 && !(acc_cnt[0] == 192 && acc_cnt[1] == 13); k++) begin
      out_ready = 2'($urandom);
      tick(1);
    end
    out_ready = 2'b11;
    tick(2);
    check("t3_count0", acc_cnt[0], 32'd192);
    check("t3_count1", acc_cnt[1], 32'd13);

    // Test 4: bursts of 3 separated by an empty FIFO.
    for (int b = 0; b < 5; b++) begin
      hold_empty[0] = 1'b1;
      for (int i = 0; i < 3; i++) push(0, DW'($urandom));
      tick(2);
      check("held_empty_rd_en", fifo_rd_en[0], 1'b0);
      hold_empty[0] = 1'b0;
      tick(8);
    end
    check("t4_count", acc_cnt[0], 32'd207);

    // Test 5: asynchronous reset with both buffers full.
    out_ready = 2'b00;
    for (int i = 0; i < 20; i++) push(0, DW'($urandom));
    for (int i = 0; i < 6; i++)  push(1, DW'($urandom));
    tick(10);
    check("pre_reset_valid", out_valid[0], 1'b1);
    #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_reset_valid", out_valid[i], 1'b0);
      check("async_reset_rd_en", fifo_rd_en[i], 1'b0);
    end
    nxt0 = mem[0][rd_ptr[0]];
    nxt1 = mem[1][rd_ptr[1]];
    tick(2);
    rst = 1'b1;
    acc_rel = acc_cnt[0];
    out_ready = 2'b11;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        found = 1'b1;
        break;
      end
    end
    check("post_reset_valid_seen", found, 1'b1);
    check("post_reset_data0", out_data[0], nxt0);
    check("post_reset_valid1", out_valid[1], 1'b1);
    check("post_reset_data1", out_data[1], nxt1);
    tick(40);
    check("t5_count0", acc_cnt[0], 32'd225);
    check("t5_count1", acc_cnt[1], 32'd14);

`ifdef FIFO_RD_STATS_EN
    // Test 6: handshake counter and its wrap.
    check("stats_count", sample_count[0], 32'(acc_cnt[0] - acc_rel));
    out_ready = 2'b00;
    push(0, DW'($urandom));
    tick(4);
    force g_dut[0].u_dut.sample_count_reg = 32'hFFFF_FFFF;
    #1;
    release g_dut[0].u_dut.sample_count_reg;
    @(negedge clk);
    check("stats_forced", sample_count[0], 32'hFFFF_FFFF);
    tick(1);
    out_ready[0] = 1'b1;
    tick(1);
    out_ready[0] = 1'b0;
    @(negedge clk);
    check("stats_wrap", sample_count[0], 32'd0);
`endif

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
